// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one TxUart transmitter between N byte requesters.
// A requester keeps ownership across a multi-byte frame until it sends a byte flagged Last.
module uart_tx_arbiter #(
  parameter int N           = 4,
  parameter int TIMEOUT_CYC = 32768
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [N-1:0]   Req,
  input  logic [8*N-1:0] ReqData,
  input  logic [N-1:0]   ReqLast,
  output logic [N-1:0]   Ack,
  output logic [N-1:0]   Grant,
  output logic           TxStart,
  output logic [7:0]     TxData,
  input  logic           TxDone,
  output logic           Busy,
  output logic           TimeoutErr
);

  localparam int             IW   = $clog2(N);
  localparam int             TW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]  TMAX = TW'(TIMEOUT_CYC);
  localparam logic [IW-1:0]  LAST = IW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT_DONE, S_WAIT_IDLE, S_ACK
  } state_e;

  state_e        state_q;
  logic [N-1:0]  ack_q, grant_q;
  logic          txstart_q, timeout_q, lock_q, last_q, done_prev_q;
  logic [7:0]    txdata_q;
  logic [IW-1:0] owner_q, rr_q;
  logic [TW-1:0] timer_q;

  logic          win_vld;
  logic [IW-1:0] win_idx, cand;
  logic [N-1:0]  win_oh;
  logic [7:0]    win_data;
  logic [TW-1:0] timer_inc;
  logic          timer_hit;

  // Scan from farthest to nearest so the requester closest after rr_q is assigned last.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    cand    = '0;
    if (lock_q) begin
      win_vld = Req[owner_q];
      win_idx = owner_q;
    end else begin
      for (int k = N; k >= 1; k--) begin
        cand = (int'(rr_q) + k >= N) ? IW'(int'(rr_q) + k - N) : IW'(int'(rr_q) + k);
        if (Req[cand]) begin
          win_vld = 1'b1;
          win_idx = cand;
        end
      end
    end
  end

  assign win_oh    = N'(1) << win_idx;
  assign win_data  = ReqData[{win_idx, 3'b000} +: 8];
  assign timer_inc = (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
  assign timer_hit = (timer_inc == TMAX);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      ack_q       <= '0;
      grant_q     <= '0;
      txstart_q   <= 1'b0;
      txdata_q    <= 8'h00;
      timeout_q   <= 1'b0;
      lock_q      <= 1'b0;
      last_q      <= 1'b0;
      done_prev_q <= 1'b0;
      owner_q     <= '0;
      rr_q        <= LAST;
      timer_q     <= '0;
    end else begin
      ack_q       <= '0;
      txstart_q   <= 1'b0;
      timeout_q   <= 1'b0;
      done_prev_q <= TxDone;
      case (state_q)
        S_IDLE: begin
          if (win_vld) begin
            grant_q   <= win_oh;
            txdata_q  <= win_data;
            last_q    <= ReqLast[win_idx];
            owner_q   <= win_idx;
            rr_q      <= win_idx;
            txstart_q <= 1'b1;
            state_q   <= S_START;
          end else if (lock_q) begin
            // Owner went silent mid-frame: release the lock so others are not starved.
            timer_q <= timer_inc;
            if (timer_hit) begin
              lock_q    <= 1'b0;
              grant_q   <= '0;
              timeout_q <= 1'b1;
              timer_q   <= '0;
            end
          end
        end
        S_START: begin
          timer_q <= '0;
          state_q <= S_WAIT_DONE;
        end
        S_WAIT_DONE: begin
          if (TxDone && !done_prev_q) begin
            state_q <= S_WAIT_IDLE;
          end else begin
            timer_q <= timer_inc;
            if (timer_hit) begin
              ack_q     <= grant_q;
              grant_q   <= '0;
              lock_q    <= 1'b0;
              timeout_q <= 1'b1;
              state_q   <= S_IDLE;
            end
          end
        end
        S_WAIT_IDLE: begin
          if (!TxDone) begin
            ack_q   <= grant_q;
            state_q <= S_ACK;
          end
        end
        S_ACK: begin
          lock_q  <= ~last_q;
          timer_q <= '0;
          if (last_q) grant_q <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Ack        = ack_q;
  assign Grant      = grant_q;
  assign TxStart    = txstart_q;
  assign TxData     = txdata_q;
  assign TimeoutErr = timeout_q;
  assign Busy       = (state_q != S_IDLE) || lock_q;

endmodule
